// File: rtl/bcd_addsub_unit.sv
// Registered N-digit packed-BCD adder/subtractor. Subtraction adds the nines
// complement of y with a carry-in of 1, so co doubles as "no borrow".
module bcd_addsub_unit #(
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  sub,
    input  logic [4*DIGITS-1:0]   x,
    input  logic [4*DIGITS-1:0]   y,
    output logic [4*DIGITS-1:0]   z,
    output logic                  co,
    output logic                  err,
    output logic                  out_valid
);

    logic [4*DIGITS-1:0] w_sum;
    logic                w_carry_out;
    logic                w_bad_digit;

    // Per-digit BCD add with decimal correction; carry ripples through all digits.
    always_comb begin
        logic       w_c;
        logic [3:0] w_xd;
        logic [3:0] w_yd;
        logic [3:0] w_yc;
        logic [4:0] w_s;
        w_sum       = '0;
        w_bad_digit = 1'b0;
        w_c         = sub;
        w_xd        = '0;
        w_yd        = '0;
        w_yc        = '0;
        w_s         = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            w_xd = x[4*i +: 4];
            w_yd = y[4*i +: 4];
            if (w_xd > 4'd9 || w_yd > 4'd9)
                w_bad_digit = 1'b1;
            w_yc = sub ? (4'd9 - w_yd) : w_yd;
            w_s  = {1'b0, w_xd} + {1'b0, w_yc} + {4'b0000, w_c};
            if (w_s > 5'd9) begin
                w_sum[4*i +: 4] = w_s[3:0] + 4'd6;
                w_c             = 1'b1;
            end else begin
                w_sum[4*i +: 4] = w_s[3:0];
                w_c             = 1'b0;
            end
        end
        w_carry_out = w_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z         <= '0;
            co        <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                if (w_bad_digit) begin
                    z   <= '0;
                    co  <= 1'b0;
                    err <= 1'b1;
                end else begin
                    z   <= w_sum;
                    co  <= w_carry_out;
                    err <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_addsub_unit.sv
// Bench for bcd_addsub_unit: directed table, pipelined/reset sequences,
// random ops against a decimal-arithmetic model, and a 1-digit exhaustive sweep.
module tb_bcd_addsub_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, sub;
    logic [11:0] x, y, z;
    logic        co, err, out_valid;
    logic        iv1, sub1;
    logic [3:0]  x1, y1, z1;
    logic        co1, err1, ov1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bcd_addsub_unit #(.DIGITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sub(sub),
        .x(x), .y(y), .z(z), .co(co), .err(err), .out_valid(out_valid)
    );

    bcd_addsub_unit #(.DIGITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .sub(sub1),
        .x(x1), .y(y1), .z(z1), .co(co1), .err(err1), .out_valid(ov1)
    );

    typedef struct {
        logic        s;
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] ez;
        logic        eco;
        logic        eerr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decimal reference: returns {err, co, z} computed from plain integer arithmetic.
    function automatic logic [13:0] model(input int d, input logic s,
                                          input logic [11:0] a, input logic [11:0] b);
        int av = 0;
        int bv = 0;
        int m  = 1;
        int r;
        int zv;
        logic bad = 1'b0;
        logic [11:0] zz = '0;
        for (int i = d - 1; i >= 0; i--) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
            av = av * 10 + int'(a[4*i +: 4]);
            bv = bv * 10 + int'(b[4*i +: 4]);
            m  = m * 10;
        end
        if (bad) return {1'b1, 1'b0, 12'h000};
        r  = s ? (av + m - bv) : (av + bv);
        zv = r % m;
        for (int i = 0; i < d; i++) begin
            zz[4*i +: 4] = 4'(zv % 10);
            zv = zv / 10;
        end
        return {1'b0, (r >= m), zz};
    endfunction

    function automatic logic [11:0] rand_bcd(input int d);
        logic [11:0] v = '0;
        for (int i = 0; i < d; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 7) == 0) v[4*$urandom_range(0, d - 1) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    vec_t tbl[12];
    logic [13:0] m;
    logic [11:0] hz;
    logic        hco, herr, hov;
    logic [13:0] pend[3];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b1, 12'h703, 12'h389, 12'h314, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 12'h389, 12'h703, 12'h686, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 12'h500, 12'h500, 12'h000, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 12'h999, 12'h001, 12'h000, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 12'h258, 12'h147, 12'h405, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 12'h70A, 12'h001, 12'h000, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 12'h70A, 12'h001, 12'h000, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 12'h123, 12'h0F0, 12'h000, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 12'h000, 12'h001, 12'h999, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 12'h000, 12'h000, 12'h000, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 12'h999, 12'h999, 12'h000, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 12'h555, 12'h445, 12'h000, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; sub = 1'b0; x = '0; y = '0;
        iv1 = 1'b0; sub1 = 1'b0; x1 = '0; y1 = '0;
        repeat (2) @(negedge clk);
        chk("reset_z", z, 0);
        chk("reset_co", co, 0);
        chk("reset_err", err, 0);
        chk("reset_ov", out_valid, 0);
        chk("reset1_ov", ov1, 0);
        rst_n = 1'b1;

        // Directed table: one op per vector, result checked one cycle later.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = 1'b1; sub = tbl[i].s; x = tbl[i].a; y = tbl[i].b;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_z", i), z, tbl[i].ez);
            chk($sformatf("tbl%0d_co", i), co, tbl[i].eco);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].eerr);
            chk($sformatf("tbl%0d_ov", i), out_valid, 1);
        end

        // Idle: outputs hold, out_valid drops (last vector was 555+445).
        x = 12'h123; y = 12'h456; sub = 1'b0;
        @(negedge clk);
        chk("hold_z", z, 12'h000);
        chk("hold_co", co, 1);
        chk("hold_ov", out_valid, 0);

        // Back-to-back add/sub/add, then reset asserted alongside in_valid.
        @(negedge clk);
        in_valid = 1'b1; sub = 1'b0; x = 12'h258; y = 12'h147;
        @(negedge clk);
        chk("b2b0_z", z, 12'h405); chk("b2b0_co", co, 0); chk("b2b0_ov", out_valid, 1);
        sub = 1'b1; x = 12'h703; y = 12'h389;
        @(negedge clk);
        chk("b2b1_z", z, 12'h314); chk("b2b1_co", co, 1); chk("b2b1_ov", out_valid, 1);
        sub = 1'b0; x = 12'h999; y = 12'h002;
        @(negedge clk);
        chk("b2b2_z", z, 12'h001); chk("b2b2_co", co, 1); chk("b2b2_ov", out_valid, 1);
        rst_n = 1'b0; sub = 1'b0; x = 12'h123; y = 12'h111;
        @(negedge clk);
        chk("rstmid_z", z, 0); chk("rstmid_co", co, 0);
        chk("rstmid_err", err, 0); chk("rstmid_ov", out_valid, 0);
        rst_n = 1'b1; in_valid = 1'b0;

        // Random ops with gaps; outputs must hold across idle cycles.
        hz = '0; hco = 1'b0; herr = 1'b0; hov = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            chk("rnd_z", z, hz); chk("rnd_co", co, hco);
            chk("rnd_err", err, herr); chk("rnd_ov", out_valid, hov);
            in_valid = ($urandom_range(0, 3) != 0);
            sub = 1'($urandom_range(0, 1));
            x = rand_bcd(3); y = rand_bcd(3);
            hov = in_valid;
            if (in_valid) begin
                m = model(3, sub, x, y);
                herr = m[13]; hco = m[12]; hz = m[11:0];
            end
        end
        @(negedge clk);
        chk("rnd_z", z, hz); chk("rnd_co", co, hco);
        chk("rnd_err", err, herr); chk("rnd_ov", out_valid, hov);
        in_valid = 1'b0;

        // 1-digit exhaustive sweep, both modes, pipelined one op per cycle.
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 10; a++) begin
                for (int b = 0; b < 10; b++) begin
                    @(negedge clk);
                    if (a != 0 || b != 0) begin
                        chk("d1_z", z1, pend[0][3:0]); chk("d1_co", co1, pend[0][12]);
                        chk("d1_err", err1, pend[0][13]); chk("d1_ov", ov1, 1);
                    end
                    iv1 = 1'b1; sub1 = 1'(s); x1 = 4'(a); y1 = 4'(b);
                    pend[0] = model(1, sub1, {8'h00, x1}, {8'h00, y1});
                end
            end
            @(negedge clk);
            iv1 = 1'b0;
            chk("d1_z", z1, pend[0][3:0]); chk("d1_co", co1, pend[0][12]);
            chk("d1_err", err1, pend[0][13]); chk("d1_ov", ov1, 1);
        end
        // Invalid digit on the 1-digit instance.
        @(negedge clk);
        iv1 = 1'b1; sub1 = 1'b0; x1 = 4'hB; y1 = 4'h1;
        @(negedge clk);
        iv1 = 1'b0;
        chk("d1_bad_err", err1, 1); chk("d1_bad_z", z1, 0); chk("d1_bad_co", co1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
